cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
// - Shares the two CDB write ports of the ROB (CDB_ROBEN1/2, write data, single branch decision) among NUM_REQ
//   functional-unit result producers (ALU0, ALU1, load/store, branch unit by default).
// - Grants up to two results per cycle with round-robin fairness, and never grants two branch results in one cycle.
// - Registers the winners onto the CDB and drives ROBEN 0 (ROB ignores it) when a port is idle.
// - Sits between the FU result stages and the ROB / reservation-station snoop logic.
// PARAMETERS
// NUM_REQ   4   number of result requesters (2..8)
// ROBEN_W   5   ROB entry number width; value 0 = no result
// DATA_W    32  result data width
// PORTS
// clk             in   1                 clock, all state on posedge
// rst             in   1                 reset, asynchronous, active-high
// flush           in   1                 ROB FLUSH_Flag; squashes grants this cycle
// req_valid       in   NUM_REQ           requester i has a result
// req_is_branch   in   NUM_REQ           result i is a branch resolution
// req_roben       in   NUM_REQ*ROBEN_W   packed ROBEN per requester
// req_data        in   NUM_REQ*DATA_W    packed result data per requester
// req_taken       in   NUM_REQ           branch decision per requester
// req_ready       out  NUM_REQ           combinational grant; transfer when valid&ready
// cdb_roben1      out  ROBEN_W           CDB port 1 ROBEN (0 = idle)
// cdb_data1       out  DATA_W            CDB port 1 data
// cdb_roben2      out  ROBEN_W           CDB port 2 ROBEN (0 = idle)
// cdb_data2       out  DATA_W            CDB port 2 data
// cdb_branch_dec  out  1                 decision of the branch granted last cycle, else 0
// err_roben0      out  1                 sticky: a valid request carried ROBEN 0
// BEHAVIOUR
// - Reset (async): all cdb_* outputs = 0, err_roben0 = 0, rr_ptr = 0. req_ready = 0 while rst is high.
// - Requester protocol: req_* held stable while valid && !ready; this is a requester obligation, checked by assertions.
// - Pick order is i = rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   - First valid requester -> port 1.
//   - Next valid requester -> port 2, unless both are branches; then port 2 takes the next valid non-branch.
//   - Otherwise port 2 is idle.
// - req_ready[i] = 1 for each picked i, in the same cycle. Latency is 1: the picked payload appears on cdb_*
//   after the next posedge. A port with no pick registers ROBEN 0 and data 0.
// - cdb_branch_dec <= req_taken of the granted branch requester, or 0 if no branch was granted.
// - rr_ptr <= (index of last granted requester + 1) mod NUM_REQ. It is unchanged when there are no grants.
// - flush = 1: req_ready = 0; next cycle cdb_roben1/2 = 0 and cdb_branch_dec = 0; rr_ptr is held.
//   Requesters are flushed by the ROB separately.
// - Valid request with ROBEN 0 is granted (consumed) but forwarded as idle, and err_roben0 <= 1.
// - No valid requests: both ports idle. Exactly one valid request: port 1 only.
// - Reset mid-transfer: registered CDB values are lost; requesters must re-present after reset.
// STRUCTURE
// - cdb_pkg: ROBEN_W, DATA_W, NUM_REQ defaults and FU index constants (FU_ALU0=0, FU_ALU1=1, FU_LS=2, FU_BR=3).
// - Sub-module rr_pick2: combinational rotate/find-first-two over valid, with the branch-exclusion mask.
//   Outputs pick1/pick2 indices plus valid bits.
// - Top level: unpack buses, instantiate rr_pick2, output registers, rr_ptr register, sticky error flag.
// TESTING
// 1. rr_ptr=0; valid=4'b1111, no branches -> ready=0011. Next cycle CDB = ROBEN(req0), ROBEN(req1); rr_ptr=2.
//    Following cycle ready=1100.
// 2. valid=4'b1001, is_branch=4'b1001, taken[3]=1, rr_ptr=3 -> only req3 granted on port 1.
//    Next cycle cdb_roben2=0, cdb_branch_dec=1.
// 3. flush=1 with valid=4'b0111 -> ready=0000. Next cycle cdb_roben1=cdb_roben2=0; rr_ptr unchanged.
// 4. Single request req2 (ROBEN=7, data=32'hDEADBEEF) -> port 1 carries 7 / DEADBEEF; port 2 ROBEN=0; rr_ptr=3.
// 5. req1 valid with ROBEN 0 -> ready[1]=1, CDB port idle, err_roben0=1 and it stays 1 until reset.
// 6. Assert rst asynchronously mid-cycle with CDB busy -> cdb_* = 0 immediately.
//    After release with all valid -> grants start at req0.

Source files
------------

// File: rtl/cdb_pkg.sv
// cdb_pkg: shared defaults and helpers for the CDB write-port arbiter.
//   NUM_REQ_DEF / ROBEN_W_DEF / DATA_W_DEF : default arbiter geometry
//   FU_*                                   : requester slot of each functional unit
//   next_idx()                             : modulo-n increment used for the round-robin pointer
package cdb_pkg;

   localparam int unsigned NUM_REQ_DEF = 4;
   localparam int unsigned ROBEN_W_DEF = 5;
   localparam int unsigned DATA_W_DEF  = 32;

   localparam int unsigned FU_ALU0 = 0;
   localparam int unsigned FU_ALU1 = 1;
   localparam int unsigned FU_LS   = 2;
   localparam int unsigned FU_BR   = 3;

   function automatic int unsigned next_idx(input int unsigned idx, input int unsigned n);
      return (idx + 1 >= n) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/cdb_arbiter_rr_pick2.sv
// rr_pick2: combinational round-robin find-first-two.
//   valid      in  : requester i has a result
//   is_branch  in  : result i is a branch resolution
//   ptr        in  : round-robin start index (0..NUM_REQ-1)
//   pick1/_valid out : first valid requester at or after ptr
//   pick2/_valid out : next valid requester after pick1; when pick1 is a
//                      branch, the next valid non-branch instead
module rr_pick2 #(
   parameter int unsigned NUM_REQ = 4,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] valid,
   input  logic [NUM_REQ-1:0] is_branch,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   pick1,
   output logic               pick1_valid,
   output logic [IDX_W-1:0]   pick2,
   output logic               pick2_valid
);

   logic br1;

   always_comb begin
      pick1       = '0;
      pick1_valid = 1'b0;
      pick2       = '0;
      pick2_valid = 1'b0;
      br1         = 1'b0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         int unsigned s;
         s = 32'(ptr) + k;
         if (s >= NUM_REQ) s = s - NUM_REQ;
         if (valid[IDX_W'(s)]) begin
            if (!pick1_valid) begin
               pick1_valid = 1'b1;
               pick1       = IDX_W'(s);
               br1         = is_branch[IDX_W'(s)];
            end else if (!pick2_valid && !(br1 && is_branch[IDX_W'(s)])) begin
               // a second branch is skipped so only one decision reaches the ROB
               pick2_valid = 1'b1;
               pick2       = IDX_W'(s);
            end
         end
      end
   end

endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the two ROB CDB write ports among NUM_REQ result producers.
//   clk, rst (async, active-high)
//   flush          in  : squash all grants this cycle
//   req_valid/req_is_branch/req_taken in [NUM_REQ] : per-requester status
//   req_roben      in  : packed NUM_REQ x ROBEN_W
//   req_data       in  : packed NUM_REQ x DATA_W
//   req_ready      out : combinational grant (transfer on valid & ready)
//   cdb_roben1/2, cdb_data1/2 out : registered winners, ROBEN 0 = idle
//   cdb_branch_dec out : taken bit of the branch granted last cycle
//   err_roben0     out : sticky, a granted request carried ROBEN 0
module cdb_arbiter
   import cdb_pkg::*;
#(
   parameter int unsigned NUM_REQ = NUM_REQ_DEF,
   parameter int unsigned ROBEN_W = ROBEN_W_DEF,
   parameter int unsigned DATA_W  = DATA_W_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   input  logic [NUM_REQ-1:0]         req_valid,
   input  logic [NUM_REQ-1:0]         req_is_branch,
   input  logic [NUM_REQ*ROBEN_W-1:0] req_roben,
   input  logic [NUM_REQ*DATA_W-1:0]  req_data,
   input  logic [NUM_REQ-1:0]         req_taken,
   output logic [NUM_REQ-1:0]         req_ready,
   output logic [ROBEN_W-1:0]         cdb_roben1,
   output logic [DATA_W-1:0]          cdb_data1,
   output logic [ROBEN_W-1:0]         cdb_roben2,
   output logic [DATA_W-1:0]          cdb_data2,
   output logic                       cdb_branch_dec,
   output logic                       err_roben0
);

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   logic [ROBEN_W-1:0] roben_arr [NUM_REQ];
   logic [DATA_W-1:0]  data_arr  [NUM_REQ];

   logic [IDX_W-1:0]   rr_ptr;
   logic [IDX_W-1:0]   pick1, pick2;
   logic               pick1_valid, pick2_valid;
   logic               grant1, grant2;

   logic [ROBEN_W-1:0] roben1_n, roben2_n;
   logic [DATA_W-1:0]  data1_n, data2_n;
   logic               dec_n;
   logic               err_hit;
   logic [IDX_W-1:0]   last_grant;

   always_comb begin
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         roben_arr[k] = req_roben[k*ROBEN_W +: ROBEN_W];
         data_arr[k]  = req_data[k*DATA_W +: DATA_W];
      end
   end

   rr_pick2 #(.NUM_REQ(NUM_REQ)) u_pick (
      .valid       (req_valid),
      .is_branch   (req_is_branch),
      .ptr         (rr_ptr),
      .pick1       (pick1),
      .pick1_valid (pick1_valid),
      .pick2       (pick2),
      .pick2_valid (pick2_valid)
   );

   assign grant1 = pick1_valid && !flush;
   assign grant2 = pick2_valid && !flush;

   always_comb begin
      req_ready = '0;
      if (!rst) begin
         if (grant1) req_ready[pick1] = 1'b1;
         if (grant2) req_ready[pick2] = 1'b1;
      end
   end

   // ROBEN 0 results are consumed but leave the port idle (roben and data 0)
   always_comb begin
      roben1_n = '0;
      data1_n  = '0;
      roben2_n = '0;
      data2_n  = '0;
      dec_n    = 1'b0;
      err_hit  = 1'b0;
      if (grant1) begin
         roben1_n = roben_arr[pick1];
         if (roben_arr[pick1] != '0) begin
            data1_n = data_arr[pick1];
            if (req_is_branch[pick1]) dec_n = req_taken[pick1];
         end else begin
            err_hit = 1'b1;
         end
      end
      if (grant2) begin
         roben2_n = roben_arr[pick2];
         if (roben_arr[pick2] != '0) begin
            data2_n = data_arr[pick2];
            if (req_is_branch[pick2]) dec_n = dec_n | req_taken[pick2];
         end else begin
            err_hit = 1'b1;
         end
      end
      last_grant = grant2 ? pick2 : pick1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cdb_roben1     <= '0;
         cdb_data1      <= '0;
         cdb_roben2     <= '0;
         cdb_data2      <= '0;
         cdb_branch_dec <= 1'b0;
         err_roben0     <= 1'b0;
         rr_ptr         <= '0;
      end else begin
         cdb_roben1     <= roben1_n;
         cdb_data1      <= data1_n;
         cdb_roben2     <= roben2_n;
         cdb_data2      <= data2_n;
         cdb_branch_dec <= dec_n;
         if (err_hit) err_roben0 <= 1'b1;
         if (grant1) rr_ptr <= IDX_W'(next_idx(32'(last_grant), NUM_REQ));
      end
   end

   // Requesters must hold their payload until granted (a flush releases them).
   for (genvar g = 0; g < NUM_REQ; g++) begin : g_hold_chk
      a_hold : assert property (@(posedge clk) disable iff (rst)
         (req_valid[g] && !req_ready[g] && !flush) |=>
            (req_valid[g]
             && $stable(req_is_branch[g])
             && $stable(req_taken[g])
             && $stable(req_roben[g*ROBEN_W +: ROBEN_W])
             && $stable(req_data[g*DATA_W +: DATA_W])));
   end

endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;

   logic         clk;
   logic         rst;
   logic         flush;
   logic [3:0]   req_valid;
   logic [3:0]   req_is_branch;
   logic [19:0]  req_roben;
   logic [127:0] req_data;
   logic [3:0]   req_taken;
   logic [3:0]   req_ready;
   logic [4:0]   cdb_roben1;
   logic [31:0]  cdb_data1;
   logic [4:0]   cdb_roben2;
   logic [31:0]  cdb_data2;
   logic         cdb_branch_dec;
   logic         err_roben0;

   int n_tests = 0;
   int n_fail  = 0;

   cdb_arbiter #(.NUM_REQ(4), .ROBEN_W(5), .DATA_W(32)) dut (
      .clk            (clk),
      .rst            (rst),
      .flush          (flush),
      .req_valid      (req_valid),
      .req_is_branch  (req_is_branch),
      .req_roben      (req_roben),
      .req_data       (req_data),
      .req_taken      (req_taken),
      .req_ready      (req_ready),
      .cdb_roben1     (cdb_roben1),
      .cdb_data1      (cdb_data1),
      .cdb_roben2     (cdb_roben2),
      .cdb_data2      (cdb_data2),
      .cdb_branch_dec (cdb_branch_dec),
      .err_roben0     (err_roben0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        flush;
      logic [3:0]  valid;
      logic [3:0]  br;
      logic [3:0]  taken;
      logic [19:0] roben;
      logic [3:0]  exp_ready;
      int          e1;
      int          e2;
      logic        exp_dec;
   } vec_t;

   vec_t tv [14];

   function automatic logic [19:0] pk(input int r3, input int r2, input int r1, input int r0);
      return {5'(r3), 5'(r2), 5'(r1), 5'(r0)};
   endfunction

   function automatic logic [31:0] data_of(input int i, input logic [4:0] r);
      return {16'hC0DE, 8'(i), 3'b000, r};
   endfunction

   function automatic vec_t mk(input logic f, input logic [3:0] v, input logic [3:0] b,
                               input logic [3:0] t, input logic [19:0] r, input logic [3:0] er,
                               input int e1, input int e2, input logic ed);
      vec_t x;
      x.flush = f; x.valid = v; x.br = b; x.taken = t; x.roben = r;
      x.exp_ready = er; x.e1 = e1; x.e2 = e2; x.exp_dec = ed;
      return x;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic apply(input vec_t x);
      flush         = x.flush;
      req_valid     = x.valid;
      req_is_branch = x.br;
      req_taken     = x.taken;
      req_roben     = x.roben;
      for (int i = 0; i < 4; i++)
         req_data[i*32 +: 32] = data_of(i, x.roben[i*5 +: 5]);
   endtask

   task automatic idle_inputs();
      flush = 1'b0; req_valid = '0; req_is_branch = '0; req_taken = '0;
      req_roben = '0; req_data = '0;
   endtask

   logic [19:0] rb;
   logic [4:0]  er1, er2;
   logic [31:0] ed1, ed2;

   initial begin
      rst = 1'b1;
      idle_inputs();

      // rr_ptr walk: 0 ->2 ->0 ->3 ->0 ->1 ->0 ->3 ->1 ->1(flush) ->3 ->1 ->1 ->3 ->1
      tv[0]  = mk(0, 4'b1111, 4'b0000, 4'b0000, pk(4,3,2,1),     4'b0011, 0, 1, 0);
      tv[1]  = mk(0, 4'b1100, 4'b0000, 4'b0000, pk(4,3,0,0),     4'b1100, 2, 3, 0);
      tv[2]  = mk(0, 4'b0100, 4'b0000, 4'b0000, pk(0,7,0,0),     4'b0100, 2, -1, 0);
      tv[3]  = mk(0, 4'b1001, 4'b1001, 4'b1000, pk(9,0,0,10),    4'b1000, 3, -1, 1);
      tv[4]  = mk(0, 4'b0001, 4'b0001, 4'b0000, pk(0,0,0,10),    4'b0001, 0, -1, 0);
      tv[5]  = mk(0, 4'b1110, 4'b0110, 4'b0010, pk(13,12,11,0),  4'b1010, 1, 3, 1);
      tv[6]  = mk(0, 4'b0100, 4'b0100, 4'b0000, pk(0,12,0,0),    4'b0100, 2, -1, 0);
      tv[7]  = mk(0, 4'b1011, 4'b0011, 4'b0011, pk(16,0,15,14),  4'b1001, 3, 0, 1);
      tv[8]  = mk(1, 4'b0111, 4'b0010, 4'b0010, pk(0,18,15,17),  4'b0000, -1, -1, 0);
      tv[9]  = mk(0, 4'b0111, 4'b0000, 4'b0000, pk(0,18,15,17),  4'b0110, 1, 2, 0);
      tv[10] = mk(0, 4'b0001, 4'b0000, 4'b0000, pk(0,0,0,17),    4'b0001, 0, -1, 0);
      tv[11] = mk(0, 4'b0000, 4'b0000, 4'b0000, pk(0,0,0,0),     4'b0000, -1, -1, 0);
      tv[12] = mk(0, 4'b1111, 4'b0000, 4'b0000, pk(4,3,2,1),     4'b0110, 1, 2, 0);
      tv[13] = mk(0, 4'b1001, 4'b0000, 4'b0000, pk(4,3,2,1),     4'b1001, 3, 0, 0);

      #12;
      check("reset ready", 32'(req_ready), 32'h0);
      check("reset roben1", 32'(cdb_roben1), 32'h0);
      check("reset roben2", 32'(cdb_roben2), 32'h0);
      check("reset err", 32'(err_roben0), 32'h0);
      @(negedge clk);
      rst = 1'b0;

      for (int v = 0; v < 14; v++) begin
         apply(tv[v]);
         #1;
         check($sformatf("v%0d ready", v), 32'(req_ready), 32'(tv[v].exp_ready));
         @(posedge clk);
         @(negedge clk);
         rb  = tv[v].roben;
         er1 = (tv[v].e1 < 0) ? 5'd0 : rb[tv[v].e1*5 +: 5];
         er2 = (tv[v].e2 < 0) ? 5'd0 : rb[tv[v].e2*5 +: 5];
         ed1 = (tv[v].e1 < 0) ? 32'd0 : data_of(tv[v].e1, er1);
         ed2 = (tv[v].e2 < 0) ? 32'd0 : data_of(tv[v].e2, er2);
         check($sformatf("v%0d roben1", v), 32'(cdb_roben1), 32'(er1));
         check($sformatf("v%0d data1", v), cdb_data1, ed1);
         check($sformatf("v%0d roben2", v), 32'(cdb_roben2), 32'(er2));
         check($sformatf("v%0d data2", v), cdb_data2, ed2);
         check($sformatf("v%0d dec", v), 32'(cdb_branch_dec), 32'(tv[v].exp_dec));
      end
      check("err still clear", 32'(err_roben0), 32'h0);

      // single request req2 with explicit payload; rr_ptr 1 -> 3
      idle_inputs();
      req_valid = 4'b0100;
      req_roben[10 +: 5] = 5'd7;
      req_data[64 +: 32] = 32'hDEADBEEF;
      #1;
      check("single ready", 32'(req_ready), 32'h4);
      @(posedge clk);
      @(negedge clk);
      check("single roben1", 32'(cdb_roben1), 32'd7);
      check("single data1", cdb_data1, 32'hDEADBEEF);
      check("single roben2", 32'(cdb_roben2), 32'd0);
      check("single data2", cdb_data2, 32'd0);

      // rr_ptr must now be 3: all valid -> picks 3 then 0
      apply(mk(0, 4'b1111, 4'b0000, 4'b0000, pk(4,3,2,1), 4'b0000, 0, 0, 0));
      #1;
      check("ptr3 ready", 32'(req_ready), 32'h9);
      @(posedge clk);
      @(negedge clk);
      check("ptr3 roben1", 32'(cdb_roben1), 32'd4);
      check("ptr3 roben2", 32'(cdb_roben2), 32'd1);
      apply(mk(0, 4'b0110, 4'b0000, 4'b0000, pk(4,3,2,1), 4'b0000, 0, 0, 0));
      #1;
      check("ptr1 ready", 32'(req_ready), 32'h6);
      @(posedge clk);
      @(negedge clk);

      // ROBEN 0 request: consumed, port idle, sticky error
      idle_inputs();
      req_valid = 4'b0010;
      req_data[32 +: 32] = 32'h12345678;
      #1;
      check("r0 ready", 32'(req_ready), 32'h2);
      @(posedge clk);
      @(negedge clk);
      idle_inputs();
      check("r0 roben1", 32'(cdb_roben1), 32'd0);
      check("r0 data1", cdb_data1, 32'd0);
      check("r0 err set", 32'(err_roben0), 32'd1);
      repeat (3) @(negedge clk);
      check("r0 err sticky", 32'(err_roben0), 32'd1);

      // asynchronous reset with the CDB busy
      req_valid = 4'b0001;
      req_roben[0 +: 5] = 5'd5;
      req_data[0 +: 32] = 32'hA5A5_0005;
      @(posedge clk);
      #2;
      check("busy roben1", 32'(cdb_roben1), 32'd5);
      rst = 1'b1;
      #1;
      check("arst roben1", 32'(cdb_roben1), 32'd0);
      check("arst data1", cdb_data1, 32'd0);
      check("arst err", 32'(err_roben0), 32'd0);
      check("arst ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      apply(mk(0, 4'b1111, 4'b0000, 4'b0000, pk(4,3,2,1), 4'b0000, 0, 0, 0));
      #1;
      check("post-rst ready", 32'(req_ready), 32'h3);
      @(posedge clk);
      @(negedge clk);
      check("post-rst roben1", 32'(cdb_roben1), 32'd1);
      check("post-rst roben2", 32'(cdb_roben2), 32'd2);
      idle_inputs();
      rst = 1'b1;
      @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
